// File: rtl/program_loader.sv
// Serial program loader: assembles a big-endian origin/count/data byte stream into
// 16-bit words, writes them through the memory direct port, then optionally reads them back.
module program_loader #(
  parameter bit VERIFY_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [15:0] address_in_direct,
  output logic [15:0] data_in_direct,
  output logic        wren_direct,
  input  logic [15:0] mem_out_direct,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] checksum
);

  typedef enum logic [3:0] {
    IDLE, ORG_H, ORG_L, CNT_H, CNT_L, DAT_H, DAT_L, WRITE, VRD, VCHK, FIN
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] origin_reg, count_reg, index_reg, word_reg, rsum_reg, checksum_reg;
  logic [7:0]  hi_reg;
  logic        busy_reg, done_reg, error_reg;

  logic        accept;
  logic [15:0] index_inc;
  logic [15:0] rsum_sum;
  logic [15:0] count_asm;
  logic        last_word;

  assign accept    = byte_ready & byte_valid;
  assign index_inc = index_reg + 16'd1;
  assign rsum_sum  = rsum_reg + mem_out_direct;
  assign count_asm = {count_reg[15:8], byte_in};
  assign last_word = !(index_inc < count_reg);

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign error    = error_reg;
  assign checksum = checksum_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Port outputs are decoded from state so an asynchronous reset clears them at once.
  always_comb begin
    state_next        = state_reg;
    byte_ready        = 1'b0;
    wren_direct       = 1'b0;
    address_in_direct = 16'd0;
    data_in_direct    = 16'd0;
    case (state_reg)
      IDLE:  if (start) state_next = ORG_H;
      ORG_H: begin byte_ready = 1'b1; if (byte_valid) state_next = ORG_L; end
      ORG_L: begin byte_ready = 1'b1; if (byte_valid) state_next = CNT_H; end
      CNT_H: begin byte_ready = 1'b1; if (byte_valid) state_next = CNT_L; end
      CNT_L: begin
        byte_ready = 1'b1;
        if (byte_valid) state_next = (count_asm == 16'd0) ? FIN : DAT_H;
      end
      DAT_H: begin byte_ready = 1'b1; if (byte_valid) state_next = DAT_L; end
      DAT_L: begin byte_ready = 1'b1; if (byte_valid) state_next = WRITE; end
      WRITE: begin
        wren_direct       = 1'b1;
        address_in_direct = origin_reg + index_reg;
        data_in_direct    = word_reg;
        if (!last_word)     state_next = DAT_H;
        else if (VERIFY_EN) state_next = VRD;
        else                state_next = FIN;
      end
      VRD: begin
        address_in_direct = origin_reg + index_reg;
        state_next        = VCHK;
      end
      VCHK:    state_next = (index_inc == count_reg) ? FIN : VRD;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      origin_reg   <= 16'd0;
      count_reg    <= 16'd0;
      index_reg    <= 16'd0;
      word_reg     <= 16'd0;
      rsum_reg     <= 16'd0;
      checksum_reg <= 16'd0;
      hi_reg       <= 8'd0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          busy_reg     <= 1'b1;
          done_reg     <= 1'b0;
          error_reg    <= 1'b0;
          checksum_reg <= 16'd0;
          index_reg    <= 16'd0;
        end
        ORG_H: if (accept) origin_reg[15:8] <= byte_in;
        ORG_L: if (accept) origin_reg[7:0]  <= byte_in;
        CNT_H: if (accept) count_reg[15:8]  <= byte_in;
        CNT_L: if (accept) begin
          count_reg[7:0] <= byte_in;
          if (count_asm == 16'd0) done_reg <= 1'b1;
        end
        DAT_H: if (accept) hi_reg   <= byte_in;
        DAT_L: if (accept) word_reg <= {hi_reg, byte_in};
        WRITE: begin
          checksum_reg <= checksum_reg + word_reg;
          index_reg    <= index_inc;
          if (last_word) begin
            // Readback walks the same address range from the start.
            index_reg <= 16'd0;
            rsum_reg  <= 16'd0;
            if (!VERIFY_EN) done_reg <= 1'b1;
          end
        end
        VCHK: begin
          rsum_reg  <= rsum_sum;
          index_reg <= index_inc;
          if (index_inc == count_reg) begin
            if (rsum_sum != checksum_reg) error_reg <= 1'b1;
            else                          done_reg  <= 1'b1;
          end
        end
        FIN:     busy_reg <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: runs a verifying and a non-verifying instance side by side
// on one byte stream, each against its own memory model with optional readback corruption.
module tb_program_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;

  logic        byte_ready_a, wren_a, busy_a, done_a, error_a;
  logic [15:0] addr_a, data_a, checksum_a;
  logic [15:0] mem_out_a = 16'd0;
  logic        byte_ready_b, wren_b, busy_b, done_b, error_b;
  logic [15:0] addr_b, data_b, checksum_b;
  logic [15:0] mem_out_b = 16'd0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  program_loader #(.VERIFY_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready_a), .address_in_direct(addr_a), .data_in_direct(data_a),
    .wren_direct(wren_a), .mem_out_direct(mem_out_a), .busy(busy_a), .done(done_a),
    .error(error_a), .checksum(checksum_a)
  );

  program_loader #(.VERIFY_EN(1'b0)) dut_nv (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready_b), .address_in_direct(addr_b), .data_in_direct(data_b),
    .wren_direct(wren_b), .mem_out_direct(mem_out_b), .busy(busy_b), .done(done_b),
    .error(error_b), .checksum(checksum_b)
  );

  logic [15:0] mem_a [0:65535];
  logic [15:0] mem_b [0:65535];
  logic        corrupt_en = 1'b0;
  logic [15:0] corrupt_addr = 16'd0;
  logic [31:0] wlog_a[$];
  logic [31:0] wlog_b[$];
  logic [15:0] words[$];

  // Synchronous-read memories; a corrupted location reads back with bit 0 flipped.
  always @(posedge clk) begin
    if (wren_a) begin mem_a[addr_a] <= data_a; wlog_a.push_back({addr_a, data_a}); end
    if (wren_b) begin mem_b[addr_b] <= data_b; wlog_b.push_back({addr_b, data_b}); end
    mem_out_a <= (corrupt_en && addr_a == corrupt_addr) ? (mem_a[addr_a] ^ 16'h0001) : mem_a[addr_a];
    mem_out_b <= (corrupt_en && addr_b == corrupt_addr) ? (mem_b[addr_b] ^ 16'h0001) : mem_b[addr_b];
  end

  // Offers one byte until accepted; with gaps, idles first and pulses start while busy.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit taken = 0;
    if (gaps) begin
      int n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) begin
        byte_valid = 1'b0;
        start = ($urandom_range(0, 1) == 1);
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    byte_in = b;
    byte_valid = 1'b1;
    for (int t = 0; t < 50 && !taken; t++) begin
      @(negedge clk);
      if (byte_ready_a) begin
        @(posedge clk); #1;
        taken = 1;
      end
    end
    byte_valid = 1'b0;
    byte_in = 8'($urandom);
    total++;
    if (!taken) begin
      bad++;
      $display("FAIL byte_accept: byte %h not accepted, byte_ready=%b required 1", b, byte_ready_a);
    end
  endtask

  task automatic pulse_start();
    wlog_a.delete();
    wlog_b.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 500 && (busy_a || busy_b); t++) begin
      @(posedge clk); #1;
    end
    total++;
    if (busy_a || busy_b) begin
      bad++;
      $display("FAIL idle_timeout: busy=%b/%b required 0/0", busy_a, busy_b);
    end
  endtask

  task automatic run_load(input logic [15:0] org, input bit gaps);
    logic [15:0] cnt;
    cnt = 16'(words.size());
    pulse_start();
    send_byte(org[15:8], gaps);
    send_byte(org[7:0], gaps);
    send_byte(cnt[15:8], gaps);
    send_byte(cnt[7:0], gaps);
    foreach (words[i]) begin
      send_byte(words[i][15:8], gaps);
      send_byte(words[i][7:0], gaps);
    end
    wait_idle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({byte_ready_a, wren_a, busy_a, done_a, error_a, addr_a, data_a, checksum_a} !== 53'd0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b wren=%b busy=%b done=%b err=%b addr=%h data=%h cs=%h required all 0",
               byte_ready_a, wren_a, busy_a, done_a, error_a, addr_a, data_a, checksum_a);
    end
    #2 reset = 1'b0;
    byte_valid = 1'b1;
    byte_in = 8'h5A;
    @(posedge clk); #1;
    repeat (3) begin
      total++;
      if (byte_ready_a !== 1'b0 || busy_a !== 1'b0) begin
        bad++;
        $display("FAIL idle_ignore: byte_ready=%b busy=%b required 0/0", byte_ready_a, busy_a);
      end
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    $display("reset: outputs cleared, idle bytes ignored");
  endtask

  task automatic test_count_zero();
    bit seen;
    words.delete();
    pulse_start();
    send_byte(8'h40, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    seen = done_a;
    @(posedge clk); #1;
    seen = seen | done_a;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL count_zero_done_latency: done=%b within 2 cycles, required 1", done_a);
    end
    wait_idle();
    total++;
    if (wlog_a.size() != 0 || wlog_b.size() != 0 || checksum_a !== 16'd0 || done_a !== 1'b1 ||
        error_a !== 1'b0 || done_b !== 1'b1 || busy_a !== 1'b0) begin
      bad++;
      $display("FAIL count_zero: writes=%0d/%0d cs=%h done=%b/%b err=%b busy=%b required 0/0 0000 1/1 0 0",
               wlog_a.size(), wlog_b.size(), checksum_a, done_a, done_b, error_a, busy_a);
    end
    $display("count_zero: org=4000 writes=%0d done=%b", wlog_a.size(), done_a);
  endtask

  task automatic test_reset_midload();
    words.delete();
    pulse_start();
    send_byte(8'h50, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    @(posedge clk); #1;
    total++;
    if (busy_a !== 1'b1 || checksum_a !== 16'h1122) begin
      bad++;
      $display("FAIL midload_before_reset: busy=%b cs=%h required 1 1122", busy_a, checksum_a);
    end
    #1 reset = 1'b1;
    #1;
    total++;
    if ({byte_ready_a, wren_a, busy_a, done_a, error_a, addr_a, data_a, checksum_a} !== 53'd0) begin
      bad++;
      $display("FAIL midload_async_reset: rdy=%b wren=%b busy=%b done=%b err=%b addr=%h data=%h cs=%h required all 0",
               byte_ready_a, wren_a, busy_a, done_a, error_a, addr_a, data_a, checksum_a);
    end
    byte_valid = 1'b1;
    byte_in = 8'h77;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 byte_valid = 1'b0;
    total++;
    if (wlog_a.size() != 1 || wlog_a[0] !== {16'h5000, 16'h1122} || wlog_b.size() != 1 || busy_a !== 1'b0) begin
      bad++;
      $display("FAIL midload_writes: writes=%0d/%0d first=%h busy=%b required 1/1 50001122 0",
               wlog_a.size(), wlog_b.size(), (wlog_a.size() > 0) ? wlog_a[0] : 32'h0, busy_a);
    end
    $display("reset_midload: writes before abort=%0d", wlog_a.size());
  endtask

  task automatic test_loads(input int n_rand);
    for (int s = 0; s < 4 + n_rand; s++) begin
      logic [15:0] org, exp_cs, rb_sum, a;
      logic [31:0] exp_w[$];
      bit gaps, exp_err;
      int n;
      words.delete();
      corrupt_en = 1'b0;
      gaps = 0;
      case (s)
        0: begin org = 16'h3000; words.push_back(16'h1234); words.push_back(16'hABCD); end
        1: begin org = 16'hFFFF; words.push_back(16'h0001); words.push_back(16'h0002); end
        2: begin
          org = 16'h3000; words.push_back(16'h1234); words.push_back(16'hABCD);
          corrupt_en = 1'b1; corrupt_addr = 16'h3001;
        end
        3: begin org = 16'h3000; words.push_back(16'h1234); words.push_back(16'hABCD); gaps = 1; end
        default: begin
          org = 16'($urandom);
          if ($urandom_range(0, 3) == 0) org = 16'hFFFD;
          n = $urandom_range(1, 6);
          for (int i = 0; i < n; i++) words.push_back(16'($urandom));
          gaps = ($urandom_range(0, 1) == 1);
          corrupt_en = ($urandom_range(0, 2) == 0);
          corrupt_addr = org + 16'($urandom_range(0, n - 1));
        end
      endcase
      exp_cs = 16'd0;
      rb_sum = 16'd0;
      foreach (words[i]) begin
        a = org + 16'(i);
        exp_w.push_back({a, words[i]});
        exp_cs = exp_cs + words[i];
        rb_sum = rb_sum + ((corrupt_en && a == corrupt_addr) ? (words[i] ^ 16'h0001) : words[i]);
      end
      exp_err = (rb_sum != exp_cs);
      run_load(org, gaps);
      total++;
      if (wlog_a.size() != exp_w.size() || wlog_b.size() != exp_w.size()) begin
        bad++;
        $display("FAIL write_count s=%0d: got %0d/%0d required %0d", s, wlog_a.size(), wlog_b.size(), exp_w.size());
      end else begin
        foreach (exp_w[i]) begin
          total++;
          if (wlog_a[i] !== exp_w[i] || wlog_b[i] !== exp_w[i]) begin
            bad++;
            $display("FAIL write s=%0d i=%0d: got %h/%h required %h", s, i, wlog_a[i], wlog_b[i], exp_w[i]);
          end
        end
      end
      total++;
      if (checksum_a !== exp_cs || checksum_b !== exp_cs) begin
        bad++;
        $display("FAIL checksum s=%0d: got %h/%h required %h", s, checksum_a, checksum_b, exp_cs);
      end
      total++;
      if (done_a !== !exp_err || error_a !== exp_err || done_b !== 1'b1 || error_b !== 1'b0) begin
        bad++;
        $display("FAIL status s=%0d: done=%b/%b err=%b/%b required %b/1 %b/0",
                 s, done_a, done_b, error_a, error_b, !exp_err, exp_err);
      end
      $display("load s=%0d org=%h words=%0d gaps=%0d corrupt=%0d cs=%h done=%b err=%b",
               s, org, words.size(), gaps, corrupt_en, checksum_a, done_a, error_a);
      corrupt_en = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_count_zero();
    test_reset_midload();
    test_loads(12);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
